// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the inter-chip link (tx now, rx later).
package noc_link_pkg;

  typedef enum logic {IDLE, SEND} link_tx_state_t;

  function automatic int calc_phits(input int fw, input int pw);
    return fw / pw;
  endfunction

  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module link_fifo #(
  parameter int W = 36,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(D+1)-1:0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D+1);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(D));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(D-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= ptr_inc(wr_q);
      if (pop_ok)  rd_q <= ptr_inc(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/chip_link_tx.sv
// Inter-chip link transmitter: flit FIFO, phit serializer, far-side credit gate.
// Optional phit parity under macro CHIP_LINK_PARITY_EN.
//   state | meaning
//   IDLE  | nothing on the pins, waiting for a flit and a link credit
//   SEND  | phit idx_q of the current flit is on the pins
module chip_link_tx
  import noc_link_pkg::*;
#(
  parameter int FW        = 36,
  parameter int B         = 4,
  parameter int PW        = 9,
  parameter int LINK_CRED = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [FW-1:0] flit_in,
  input  logic          flit_in_wr,
  output logic          credit_out,
  output logic [PW-1:0] phit_out,
  output logic          phit_out_vld,
  output logic          phit_out_sof,
  output logic          phit_out_par,
  input  logic          link_credit_in,
  output logic          overflow_err,
  output logic          credit_err
);
  localparam int PHITS = calc_phits(FW, PW);
  localparam int IW    = (PHITS > 1) ? $clog2(PHITS) : 1;
  localparam int LCW   = $clog2(LINK_CRED+1);

  link_tx_state_t  state_q;
  logic [IW-1:0]   idx_q;
  logic [FW-1:0]   sreg_q;
  logic [LCW-1:0]  lcred_q;
  logic [PW-1:0]   phit_q;
  logic            vld_q, sof_q, credit_q, ovf_q, cerr_q, par_q;

  logic [FW-1:0]   head;
  logic [$clog2(B+1)-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic            last_phit, launch, advance;
  logic [PW-1:0]   phit_nxt;

  link_fifo #(.W(FW), .D(B)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (flit_in_wr),
    .din_i   (flit_in),
    .pop_i   (launch),
    .dout_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign last_phit = (idx_q == IW'(PHITS-1));
  assign launch    = !fifo_empty && (lcred_q != '0) && ((state_q == IDLE) || last_phit);
  assign advance   = (state_q == SEND) && !last_phit;
  // sreg_q is pre-shifted so its top slice is always the next phit to emit
  assign phit_nxt  = launch ? head[FW-1 -: PW] : sreg_q[FW-1 -: PW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sreg_q   <= '0;
      lcred_q  <= LCW'(LINK_CRED);
      phit_q   <= '0;
      vld_q    <= 1'b0;
      sof_q    <= 1'b0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      cerr_q   <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      credit_q <= launch;
      if (flit_in_wr && fifo_full && !launch) ovf_q <= 1'b1;
      if (link_credit_in && (lcred_q == LCW'(LINK_CRED))) cerr_q <= 1'b1;

      if (launch && !link_credit_in)
        lcred_q <= lcred_q - LCW'(1);
      else if (!launch && link_credit_in && (lcred_q != LCW'(LINK_CRED)))
        lcred_q <= lcred_q + LCW'(1);

      if (launch) begin
        state_q <= SEND;
        idx_q   <= '0;
        sreg_q  <= head << PW;
        phit_q  <= phit_nxt;
        vld_q   <= 1'b1;
        sof_q   <= 1'b1;
      end else if (advance) begin
        idx_q   <= idx_q + IW'(1);
        sreg_q  <= sreg_q << PW;
        phit_q  <= phit_nxt;
        vld_q   <= 1'b1;
        sof_q   <= 1'b0;
      end else begin
        state_q <= IDLE;
        vld_q   <= 1'b0;
        sof_q   <= 1'b0;
      end

`ifdef CHIP_LINK_PARITY_EN
      par_q <= (launch || advance) ? even_parity(64'(phit_nxt)) : 1'b0;
`else
      par_q <= 1'b0;
`endif
    end
  end

  assign credit_out   = credit_q;
  assign phit_out     = phit_q;
  assign phit_out_vld = vld_q;
  assign phit_out_sof = sof_q;
  assign phit_out_par = par_q;
  assign overflow_err = ovf_q;
  assign credit_err   = cerr_q;
endmodule

// File: tb/tb_chip_link_tx.sv
// Bench for chip_link_tx: directed scenarios plus random traffic against a queue-based model.
module tb_chip_link_tx;
  localparam int FW = 36;
  localparam int B = 4;
  localparam int PW = 9;
  localparam int LC = 4;
  localparam int PHITS = FW / PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] flit_in = '0;
  logic          flit_in_wr = 1'b0;
  logic          link_credit_in = 1'b0;
  logic          credit_out, phit_out_vld, phit_out_sof, phit_out_par;
  logic          overflow_err, credit_err;
  logic [PW-1:0] phit_out;

  int n_checks = 0;
  int n_fail = 0;

  chip_link_tx #(.FW(FW), .B(B), .PW(PW), .LINK_CRED(LC)) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_in_wr     (flit_in_wr),
    .credit_out     (credit_out),
    .phit_out       (phit_out),
    .phit_out_vld   (phit_out_vld),
    .phit_out_sof   (phit_out_sof),
    .phit_out_par   (phit_out_par),
    .link_credit_in (link_credit_in),
    .overflow_err   (overflow_err),
    .credit_err     (credit_err)
  );

  always #5 clk = ~clk;

  // reference model: pending flits, credits, and phits still owed for the current flit
  logic [FW-1:0] m_q[$];
  logic [FW-1:0] m_cur;
  int            m_lcred, m_left;
  logic [PW-1:0] e_phit;
  logic          e_vld, e_sof, e_cred, e_ovf, e_cerr;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clk(input logic r, input logic wr, input logic [FW-1:0] f, input logic lc);
    logic launch, ok;
    logic [FW-1:0] tmp;
    int k;
    if (r) begin
      m_q.delete();
      m_lcred = LC; m_left = 0; m_cur = '0;
      e_phit = '0; e_vld = 0; e_sof = 0; e_cred = 0; e_ovf = 0; e_cerr = 0;
      return;
    end
    launch = (m_q.size() > 0) && (m_lcred > 0) && (m_left == 0);
    ok = (m_q.size() < B) || launch;
    e_cred = launch;
    if (launch) begin
      m_cur = m_q.pop_front();
      e_phit = m_cur[FW-1 -: PW];
      e_vld = 1; e_sof = 1;
      m_left = PHITS - 1;
    end else if (m_left > 0) begin
      k = PHITS - m_left;
      tmp = m_cur >> (FW - (k + 1) * PW);
      e_phit = tmp[PW-1:0];
      e_vld = 1; e_sof = 0;
      m_left--;
    end else begin
      e_vld = 0; e_sof = 0;
    end
    if (wr) begin
      if (ok) m_q.push_back(f);
      else e_ovf = 1;
    end
    if (lc && m_lcred == LC) e_cerr = 1;
    m_lcred = m_lcred - int'(launch) + int'(lc);
    if (m_lcred > LC) m_lcred = LC;
  endtask

  task automatic step(input logic r, input logic wr, input logic [FW-1:0] f, input logic lc);
    logic e_par;
    rst = r; flit_in_wr = wr; flit_in = f; link_credit_in = lc;
    @(posedge clk);
    model_clk(r, wr, f, lc);
    #1;
`ifdef CHIP_LINK_PARITY_EN
    e_par = e_vld ? ^e_phit : 1'b0;
`else
    e_par = 1'b0;
`endif
    check_val("vld", 64'(phit_out_vld), 64'(e_vld));
    check_val("sof", 64'(phit_out_sof), 64'(e_sof));
    check_val("credit_out", 64'(credit_out), 64'(e_cred));
    check_val("phit", 64'(phit_out), 64'(e_phit));
    check_val("par", 64'(phit_out_par), 64'(e_par));
    check_val("overflow_err", 64'(overflow_err), 64'(e_ovf));
    check_val("credit_err", 64'(credit_err), 64'(e_cerr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [FW-1:0] rnd_flit();
    return {4'($urandom_range(0, 15)), 32'($urandom)};
  endfunction

  initial begin
    logic [PW-1:0] exp_ph [4];
    logic          exp_par [4];
    int vcnt, scnt, ccnt;
    int sof_at[$];

    exp_ph[0] = 9'h024; exp_ph[1] = 9'h0D1; exp_ph[2] = 9'h0B3; exp_ph[3] = 9'h189;
    exp_par[0] = 0; exp_par[1] = 0; exp_par[2] = 1; exp_par[3] = 0;

    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check_val("reset_vld", 64'(phit_out_vld), 64'(0));
    check_val("reset_credit", 64'(credit_out), 64'(0));

    // single known flit
    step(1'b0, 1'b1, 36'h123456789, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      check_val("single_phit", 64'(phit_out), 64'(exp_ph[k]));
      check_val("single_sof", 64'(phit_out_sof), 64'(k == 0));
      check_val("single_credit", 64'(credit_out), 64'(k == 0));
`ifdef CHIP_LINK_PARITY_EN
      check_val("single_par", 64'(phit_out_par), 64'(exp_par[k]));
`endif
    end
    idle(3);

    // three back-to-back flits, lcred = 3
    vcnt = 0; ccnt = 0; sof_at.delete();
    for (int i = 0; i < 17; i++) begin
      step(1'b0, i < 3, (i < 3) ? rnd_flit() : '0, 1'b0);
      vcnt += int'(phit_out_vld);
      ccnt += int'(credit_out);
      if (phit_out_sof) sof_at.push_back(i);
    end
    check_val("b2b_vld_cycles", 64'(vcnt), 64'(12));
    check_val("b2b_credits", 64'(ccnt), 64'(3));
    check_val("b2b_sof_count", 64'(sof_at.size()), 64'(3));
    if (sof_at.size() == 3) begin
      check_val("b2b_sof0", 64'(sof_at[0]), 64'(1));
      check_val("b2b_sof1", 64'(sof_at[1]), 64'(5));
      check_val("b2b_sof2", 64'(sof_at[2]), 64'(9));
    end

    // lcred is 0: five pushes, fifth overflows, nothing leaves
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i < 5, (i < 5) ? rnd_flit() : '0, 1'b0);
      vcnt += int'(phit_out_vld);
    end
    check_val("stall_vld", 64'(vcnt), 64'(0));
    check_val("overflow_set", 64'(overflow_err), 64'(1));
    scnt = 0;
    for (int i = 0; i < 26; i++) begin
      step(1'b0, 1'b0, '0, i < 4);
      scnt += int'(phit_out_sof);
    end
    check_val("drain_flits", 64'(scnt), 64'(4));

    // over-return of link credits
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
    check_val("credit_err_set", 64'(credit_err), 64'(1));
    idle(2);

    // reset while phit 2 is on the pins
    step(1'b0, 1'b1, rnd_flit(), 1'b0);
    idle(3);
    step(1'b1, 1'b0, '0, 1'b0);
    check_val("rst_mid_vld", 64'(phit_out_vld), 64'(0));
    check_val("rst_mid_credit", 64'(credit_out), 64'(0));
    check_val("rst_mid_ovf", 64'(overflow_err), 64'(0));
    idle(3);
    scnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, i < 4, (i < 4) ? rnd_flit() : '0, 1'b0);
      scnt += int'(phit_out_sof);
    end
    check_val("post_rst_flits", 64'(scnt), 64'(4));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 1), rnd_flit(),
           ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/chip_link_tx.md
# chip_link_tx

Transmit side of the inter-chip connection attached to one boundary port of the NoC mesh (E/N/W/S edge). It consumes the FW-bit flit stream and write strobe the edge mesh router drives out, and buffers flits in a B-deep FIFO. It returns one credit per flit freed to the router and serializes each flit into FW/PW narrow phits on the off-chip pins. Off-chip flow control is credit-based: a far-side credit counter gates every flit launch.

## Interface
Parameters:
- FW, 36, flit width; must be an integer multiple of PW
- B, 4, input FIFO depth in flits; equals the router buffer depth so the router's credit count matches
- PW, 9, phit (pin bus) width
- LINK_CRED, 4, far-side receive buffer depth in flits; initial link credit count

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- flit_in  input  FW  flit from the router boundary output
- flit_in_wr  input  1  flit_in valid, one flit per cycle
- credit_out  output  1  one-cycle pulse per flit popped from the FIFO; goes to the router's credit_in for this port
- phit_out  output  PW  serialized phit
- phit_out_vld  output  1  phit_out valid
- phit_out_sof  output  1  first phit of a flit
- phit_out_par  output  1  even parity of phit_out (see Configuration)
- link_credit_in  input  1  one-cycle pulse per flit slot freed at the far side
- overflow_err  output  1  sticky; write while the FIFO is full with no same-cycle pop
- credit_err  output  1  sticky; link credit returned while the counter is at LINK_CRED

## Operation
- PHITS = FW/PW. Phits are sent MSB slice first: phit k = flit[FW-1-k*PW -: PW].
- FIFO:
  - Push on flit_in_wr.
  - Push is accepted when count < B, or when a pop happens in the same cycle.
  - Otherwise the flit is dropped, overflow_err is set, and FIFO contents are unchanged.
- Link credit counter lcred:
  - Width $clog2(LINK_CRED+1).
  - −1 on launch, +1 on link_credit_in; both in the same cycle leaves it unchanged.
  - +1 when already at LINK_CRED: saturate and set credit_err.
- Launch condition: FIFO non-empty AND lcred > 0 AND (state == IDLE OR (state == SEND AND idx == PHITS-1)).
- On launch:
  - Pop the head into shift register sreg.
  - Decrement lcred.
  - Register credit_out = 1 for the next cycle.
- FSM states:
  - IDLE: phit_out_vld = 0. Launch → SEND with idx = 0.
  - SEND: drive phit idx of sreg with vld = 1 and sof = (idx == 0); idx increments each cycle.
  - At idx == PHITS-1: if launch, reload and go to idx 0 with no bubble; else → IDLE.
- credit_out and the phit outputs are registered. phit_out holds its last value while vld = 0.
- Reset values:
  - All outputs 0; FIFO empty; state IDLE; idx 0; lcred = LINK_CRED; both error flags clear.
- Reset during SEND: the partial flit is abandoned without completion. The far side discards any flit without its full phit count.

## Timing
- flit_in_wr in cycle t → FIFO non-empty at t+1 → launch at t+1 → phit 0 with sof, and the credit_out pulse, both visible in cycle t+2.
- Phits k = 1..PHITS-1 follow in cycles t+2+k.
- Sustained throughput is one flit per PHITS cycles when lcred > 0. Back-to-back flits have no idle cycle between the last phit and the next sof.
- link_credit_in in cycle t is usable by the launch decision in t+1.
- When lcred == 0 with the FIFO non-empty, the block stalls in IDLE with no credit_out and no vld.

## Configuration
- Macro CHIP_LINK_PARITY_EN.
- Defined: phit_out_par = ^phit_out, registered alongside phit_out; 0 whenever vld = 0.
- Undefined: no parity logic; phit_out_par tied 0.
- Port list is identical in both builds.

## Structure
- Shared package noc_link_pkg holds:
  - typedef enum {IDLE, SEND} link_tx_state_t
  - a function computing PHITS
  - the parity helper, shared with the future chip_link_rx
- One sub-module: link_fifo, a synchronous FIFO parameterized by width and depth, exposing count, full and empty. The FSM, serializer and credit counter stay in chip_link_tx.

## Test plan
- Single flit 36'h123456789 with lcred = 4 → phits 0x024, 0x0D1, 0x0B3, 0x189 in cycles t+2..t+5; sof only on the first; one credit_out at t+2; parity (macro on) 0, 0, 1, 0.
- Writes of flits A, B, C in consecutive cycles → 12 contiguous vld cycles; sof at t+2, t+6, t+10; three credit_out pulses spaced 4 apart.
- Set LINK_CRED = 2, push 3 flits, no link credits → 2 flits sent, then vld low. A link_credit_in pulse at cycle u → third flit's sof at u+2.
- Push 5 flits while lcred = 0 → 4 stored; 5th dropped and overflow_err = 1. After credits return, exactly 4 flits are sent.
- link_credit_in pulse with lcred = LINK_CRED → credit_err = 1 and lcred stays at 4. A simultaneous launch plus credit pulse leaves lcred unchanged.
- Assert rst at phit 2 of a flit → next cycle vld = 0, credit_out = 0, lcred = LINK_CRED, FIFO empty.
